// File: rtl/rot_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rot_pkg
//  Description : Shared constants and command type for the rotate-right
//                command stager and its FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
package rot_pkg;

    // Data width of the downstream barrel shifter and its select width.
    localparam int W  = 8;
    localparam int AW = 3;

    // One queued rotate command: the word and its rotate-right amount.
    typedef struct packed {
        logic [W-1:0]  data;
        logic [AW-1:0] amt;
    } rot_cmd_t;

    // Packs a data word and amount into a command.
    function automatic rot_cmd_t make_cmd(input logic [W-1:0] data,
                                          input logic [AW-1:0] amt);
        rot_cmd_t c;
        c.data = data;
        c.amt  = amt;
        return c;
    endfunction

endpackage : rot_pkg
`default_nettype wire

// File: rtl/rot_cmd_stager_if.sv
`default_nettype none
// ============================================================================
//  Module      : rot_cmd_stager_if
//  Description : Bundle of the producer handshake, the shifter hookup and
//                the result handshake of the rotate command stager.
//                "slave" is the stager's view, "master" the parent's view.
//  Revision    : 1.0 - initial release
// ============================================================================
interface rot_cmd_stager_if #(
    parameter int DEPTH = 4,
    parameter int W     = rot_pkg::W,
    parameter int AW    = rot_pkg::AW
) ();

    localparam int LW = $clog2(DEPTH) + 1;

    // Producer side
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic [AW-1:0] in_amt;

    // Shifter hookup (shifter is combinational, owned by the parent)
    logic [W-1:0]  sh_d;
    logic [AW-1:0] sh_c;
    logic [W-1:0]  sh_q;

    // Consumer side
    logic          res_valid;
    logic          res_ready;
    logic [W-1:0]  res_data;
    logic [AW-1:0] res_amt;

    // Status
    logic [LW-1:0] level;
    logic          ovf_err;

    modport slave (
        input  in_valid, in_data, in_amt, sh_q, res_ready,
        output in_ready, sh_d, sh_c, res_valid, res_data, res_amt,
               level, ovf_err
    );

    modport master (
        output in_valid, in_data, in_amt, sh_q, res_ready,
        input  in_ready, sh_d, sh_c, res_valid, res_data, res_amt,
               level, ovf_err
    );

endinterface : rot_cmd_stager_if
`default_nettype wire

// File: rtl/rot_cmd_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : rot_cmd_fifo
//  Description : DEPTH-entry synchronous FIFO of rotate commands. The head
//                entry is shown combinationally from registered state only
//                (zero when empty). Push while full and pop while empty are
//                ignored so the occupancy can never go out of range.
//  Revision    : 1.0 - initial release
// ============================================================================
module rot_cmd_fifo
    import rot_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    input  wire logic                   i_push,
    input  wire rot_cmd_t               i_cmd,
    input  wire logic                   i_pop,
    output rot_cmd_t                    o_head,
    output logic [$clog2(DEPTH):0]      o_level,
    output logic                        o_full,
    output logic                        o_empty
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] C_FULL = (PW+1)'(DEPTH);

    rot_cmd_t        r_mem [DEPTH];
    logic [PW-1:0]   r_wr;
    logic [PW-1:0]   r_rd;
    logic [PW:0]     r_level;

    logic            w_push;
    logic            w_pop;

    assign o_full  = (r_level == C_FULL);
    assign o_empty = (r_level == '0);
    assign o_level = r_level;

    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop  & ~o_empty;

    // Head is zero while empty so the shifter inputs are quiet and defined.
    assign o_head  = o_empty ? '0 : r_mem[r_rd];

    // Storage write; contents need no reset because occupancy guards reads.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr] <= i_cmd;
        end
    end

    // Pointers wrap naturally at DEPTH because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_push) begin
                r_wr <= r_wr + 1'b1;
            end
            if (w_pop) begin
                r_rd <= r_rd + 1'b1;
            end
        end
    end

    // Occupancy: a simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_level <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule : rot_cmd_fifo
`default_nettype wire

// File: rtl/rot_cmd_stager.sv
`default_nettype none
// ============================================================================
//  Module      : rot_cmd_stager
//  Description : Feed stage for the combinational rotate-right shifter.
//                Commands are queued in a small FIFO, the head command drives
//                the shifter, and the shifter result is captured into a
//                valid/ready result register. A sticky flag records any
//                push attempted while the FIFO was full.
//  Revision    : 1.0 - initial release
// ============================================================================
module rot_cmd_stager #(
    parameter int DEPTH = 4,
    parameter int W     = rot_pkg::W,
    parameter int AW    = rot_pkg::AW
) (
    input  wire logic        clk,
    input  wire logic        rst,
    rot_cmd_stager_if.slave  bus
);

    import rot_pkg::*;

    localparam int LW = $clog2(DEPTH) + 1;

    rot_cmd_t        w_push_cmd;
    rot_cmd_t        w_head;
    logic            w_full;
    logic            w_empty;
    logic [LW-1:0]   w_level;
    logic            w_push;
    logic            w_pop;
    logic            w_can_load;

    logic            r_res_valid;
    logic [W-1:0]    r_res_data;
    logic [AW-1:0]   r_res_amt;
    logic            r_ovf_err;

    // Acceptance depends only on registered occupancy: no pass-through
    // when full even if the consumer is draining this cycle.
    assign bus.in_ready = ~w_full;
    assign w_push       = bus.in_valid & ~w_full;

    // The result register can take a new value when empty or being drained.
    assign w_can_load   = ~r_res_valid | bus.res_ready;
    assign w_pop        = ~w_empty & w_can_load;

    assign w_push_cmd   = make_cmd(bus.in_data, bus.in_amt);

    rot_cmd_fifo #(
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_cmd   (w_push_cmd),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_level (w_level),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Head command feeds the external shifter; it only moves on clock edges.
    assign bus.sh_d     = w_head.data;
    assign bus.sh_c     = w_head.amt;

    // Result register: load the shifter output on pop, clear valid once
    // consumed with nothing new behind it; data/amount hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_amt   <= '0;
        end else if (w_pop) begin
            r_res_valid <= 1'b1;
            r_res_data  <= bus.sh_q;
            r_res_amt   <= w_head.amt;
        end else if (r_res_valid & bus.res_ready) begin
            r_res_valid <= 1'b0;
        end
    end

    // Sticky overflow flag: a command offered while full is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf_err <= 1'b0;
        end else if (bus.in_valid & w_full) begin
            r_ovf_err <= 1'b1;
        end
    end

    assign bus.res_valid = r_res_valid;
    assign bus.res_data  = r_res_data;
    assign bus.res_amt   = r_res_amt;
    assign bus.level     = w_level;
    assign bus.ovf_err   = r_ovf_err;

endmodule : rot_cmd_stager
`default_nettype wire
